phase_sequencer: RTL and testbench

//  Parametrised multi-phase clock-enable generator for the CPU core. Emits N mutually

---
 rtl/phase_sequencer_pkg.sv | 21 ++
 rtl/phase_sequencer_if.sv | 41 ++++
 rtl/phase_sequencer_onehot_dec.sv | 23 ++
 rtl/phase_sequencer.sv | 134 +++++++++++++
 tb/tb_phase_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer_pkg
// Purpose  : Shared constants for the phase sequencer. These are the sequencer
//            state encoding and the two halt-mode selector values.
// Revision : 1.0 - initial release
// ============================================================================
package phase_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_run    = 2'd0;
    localparam state_t c_st_halted = 2'd1;
    localparam state_t c_st_step   = 2'd2;

    // Halt-mode selector values for the HALT_MODE parameter
    localparam int c_halt_mode_boundary  = 0;
    localparam int c_halt_mode_immediate = 1;

endpackage : phase_sequencer_pkg
`default_nettype wire

// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer_if
// Purpose  : Control and status bundle of the phase sequencer.
//            master : drives halt/step, observes phase and status outputs
//            slave  : the sequencer itself
//   halt        level request to stop
//   step        single-step request while halted
//   phase_pulse one-hot phase enables
//   phase_idx   index of the phase emitted next
//   cycle_done  marks the last phase of an instruction cycle
//   halted      sequencer is in the halted state
//   cycle_count completed instruction cycles
// Revision : 1.0 - initial release
// ============================================================================
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    logic                  halt;
    logic                  step;
    logic [NUM_PHASES-1:0] phase_pulse;
    logic [IDX_W-1:0]      phase_idx;
    logic                  cycle_done;
    logic                  halted;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output halt, step,
        input  phase_pulse, phase_idx, cycle_done, halted, cycle_count
    );

    modport slave (
        input  halt, step,
        output phase_pulse, phase_idx, cycle_done, halted, cycle_count
    );

endinterface : phase_sequencer_if
`default_nettype wire

// File: rtl/phase_sequencer_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer_onehot_dec
// Purpose  : Binary phase index to one-hot phase vector. An index outside
//            0..NUM_PHASES-1 decodes to all zeros.
//   i_idx     phase index
//   o_onehot  one-hot phase vector
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer_onehot_dec #(
    parameter int NUM_PHASES = 3,
    parameter int IDX_W      = 2
) (
    input  wire logic [IDX_W-1:0]      i_idx,
    output logic      [NUM_PHASES-1:0] o_onehot
);

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_bit
        assign o_onehot[i] = (i_idx == IDX_W'(i));
    end

endmodule : phase_sequencer_onehot_dec
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Purpose  : Multi-phase clock-enable generator. Emits NUM_PHASES mutually
//            exclusive one-cycle phase pulses per instruction cycle. It
//            supports halting at the cycle boundary or immediately,
//            single-stepping, and a completed-cycle counter.
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous reset, active low
//   bus    phase_sequencer_if.slave: halt/step in; phase_pulse, phase_idx,
//          cycle_done, halted, cycle_count out (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES    = 3,
    parameter int HALT_MODE     = 0,
    parameter int START_RUNNING = 1,
    parameter int CNT_W         = 16
) (
    input wire logic          clk,
    input wire logic          rst_n,
    phase_sequencer_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_PHASES);

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_PHASES - 1);
    localparam logic             c_immediate = (HALT_MODE == c_halt_mode_immediate);
    localparam state_t           c_st_reset  = (START_RUNNING != 0) ? c_st_run : c_st_halted;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_PHASES-1:0] r_pulse;
    logic                  r_done;
    logic [CNT_W-1:0]      r_count;

    state_t                w_state_next;
    logic                  w_emit;
    logic                  w_is_last;
    logic                  w_idx_legal;
    logic [IDX_W-1:0]      w_idx_next;
    logic [NUM_PHASES-1:0] w_dec;

    phase_sequencer_onehot_dec #(
        .NUM_PHASES (NUM_PHASES),
        .IDX_W      (IDX_W)
    ) u_dec (
        .i_idx    (r_idx),
        .o_onehot (w_dec)
    );

    assign w_is_last  = (r_idx == c_last_idx);
    assign w_idx_next = w_is_last ? '0 : r_idx + 1'b1;

    // With a power-of-two phase count every index is legal. Otherwise
    // codes past the last phase can only appear through corruption.
    if ((1 << IDX_W) == NUM_PHASES) begin : g_idx_pow2
        assign w_idx_legal = 1'b1;
    end else begin : g_idx_npow2
        assign w_idx_legal = (r_idx <= c_last_idx);
    end

    // Next-state and emit decision. The decision takes effect on the
    // registered outputs at the following edge.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        case (r_state)
            c_st_run: begin
                // Boundary mode only honours halt before phase 0, so a
                // started cycle always runs to completion.
                if (bus.halt && (c_immediate || (r_idx == '0))) begin
                    w_state_next = c_st_halted;
                end else begin
                    w_emit = 1'b1;
                end
            end
            c_st_halted: begin
                if (!bus.halt) begin
                    w_state_next = c_st_run;
                end else if (bus.step) begin
                    w_state_next = c_st_step;
                end
            end
            c_st_step: begin
                // A step is one phase in immediate mode, or the remainder of
                // the cycle in boundary mode. Step requests that arrive here
                // are ignored. If halt has dropped by the last stepped phase,
                // running continues without a gap.
                w_emit = 1'b1;
                if (c_immediate || w_is_last) begin
                    w_state_next = bus.halt ? c_st_halted : c_st_run;
                end
            end
            default: begin
                w_state_next = c_st_halted;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_reset;
            r_idx   <= '0;
            r_pulse <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pulse <= '0;
            r_done  <= 1'b0;
            if (!w_idx_legal) begin
                r_idx <= '0;
            end else if (w_emit) begin
                r_pulse <= w_dec;
                r_idx   <= w_idx_next;
                if (w_is_last) begin
                    r_done  <= 1'b1;
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.phase_pulse = r_pulse;
    assign bus.phase_idx   = r_idx;
    assign bus.cycle_done  = r_done;
    assign bus.halted      = (r_state == c_st_halted);
    assign bus.cycle_count = r_count;

endmodule : phase_sequencer
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sequencer
// Purpose  : Self-checking bench. It runs four sequencer configurations
//            side by side and compares each against a behavioural model
//            every cycle. Directed scenarios come first, followed by
//            randomized halt/step/reset traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

    localparam int NDUT = 4;

    function automatic int cfg_n(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_hm(input int i);
        return (i == 1 || i == 3) ? 1 : 0;
    endfunction

    function automatic int cfg_sr(input int i);
        return (i < 2) ? 1 : 0;
    endfunction

    function automatic int cfg_cw(input int i);
        return (i == 1 || i == 2) ? 4 : 16;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        halt_v   [NDUT];
    logic        step_v   [NDUT];
    logic [31:0] w_pulse  [NDUT];
    logic [31:0] w_idx    [NDUT];
    logic [31:0] w_count  [NDUT];
    logic        w_done   [NDUT];
    logic        w_halted [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int N  = cfg_n(g);
        localparam int HM = cfg_hm(g);
        localparam int SR = cfg_sr(g);
        localparam int CW = cfg_cw(g);

        phase_sequencer_if #(.NUM_PHASES(N), .CNT_W(CW)) u_if ();

        assign u_if.halt = halt_v[g];
        assign u_if.step = step_v[g];

        phase_sequencer #(
            .NUM_PHASES    (N),
            .HALT_MODE     (HM),
            .START_RUNNING (SR),
            .CNT_W         (CW)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );

        assign w_pulse[g]  = 32'(u_if.phase_pulse);
        assign w_idx[g]    = 32'(u_if.phase_idx);
        assign w_count[g]  = 32'(u_if.cycle_count);
        assign w_done[g]   = u_if.cycle_done;
        assign w_halted[g] = u_if.halted;
    end

    // ------------------------------------------------------------------
    // Behavioural model. mode: 0 running, 1 halted, 2 stepping.
    // left counts the phases still owed by the current step.
    // ------------------------------------------------------------------
    typedef struct {
        int mode;
        int nxt;
        int left;
        int ph;
        bit done;
        int cnt;
    } mdl_t;

    mdl_t m [NDUT];
    bit   m_valid = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    function automatic mdl_t emit(input mdl_t s, input int n, input int cw);
        mdl_t t = s;
        t.ph   = t.nxt;
        t.done = (t.nxt == n - 1);
        if (t.done) t.cnt = (t.cnt + 1) % (1 << cw);
        t.nxt  = (t.nxt + 1) % n;
        return t;
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input int i, input bit r, input bit h, input bit st);
        mdl_t t;
        int   n;
        int   hm;
        int   cw;
        t  = s;
        n  = cfg_n(i);
        hm = cfg_hm(i);
        cw = cfg_cw(i);
        if (!r) begin
            t.mode = (cfg_sr(i) != 0) ? 0 : 1;
            t.nxt  = 0;
            t.left = 0;
            t.ph   = -1;
            t.done = 1'b0;
            t.cnt  = 0;
            return t;
        end
        t.ph   = -1;
        t.done = 1'b0;
        case (t.mode)
            0: begin
                if (h && (hm == 1 || t.nxt == 0)) t.mode = 1;
                else                              t = emit(t, n, cw);
            end
            1: begin
                if (!h) t.mode = 0;
                else if (st) begin
                    t.mode = 2;
                    t.left = (hm == 1) ? 1 : (n - t.nxt);
                end
            end
            default: begin
                t = emit(t, n, cw);
                t.left--;
                if (t.left == 0) t.mode = h ? 1 : 0;
            end
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int d);
        checks++;
        failures++;
        $display("FAIL %s dut%0d actual=timeout required=event t=%0t", name, d, $time);
    endtask

    // Model update, sampling the same inputs the DUTs see at the edge
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) m[i] = mstep(m[i], i, rst_n, halt_v[i], step_v[i]);
        if (!rst_n) m_valid = 1'b1;
    end

    // Compare process: every DUT output against the model each cycle
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int i = 0; i < NDUT; i++) begin
                chk("pulse",  i, w_pulse[i], (m[i].ph < 0) ? 32'd0 : (32'd1 << m[i].ph));
                chk("idx",    i, w_idx[i],   32'(m[i].nxt));
                chk("done",   i, 32'(w_done[i]),   32'(m[i].done));
                chk("halted", i, 32'(w_halted[i]), 32'(m[i].mode == 1));
                chk("count",  i, w_count[i], 32'(m[i].cnt));
            end
        end
    end

    task automatic wait_pulse(input int d, input int b, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (w_pulse[d] == (32'd1 << b)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail(name, d);
    endtask

    task automatic wait_halted(input int d, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (w_halted[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail(name, d);
    endtask

    // Step from halted with step held for two edges (the second edge lands
    // in the stepping state and must be ignored), then count pulses.
    task automatic do_step(input int d, input int exp_np, input string name);
        int np = 0;
        int c0;
        c0 = m[d].cnt;
        step_v[d] = 1'b1;
        @(negedge clk);
        chk({name, "_entry"}, d, w_pulse[d], 32'd0);
        @(negedge clk);
        np += (w_pulse[d] != 0) ? 1 : 0;
        step_v[d] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            np += (w_pulse[d] != 0) ? 1 : 0;
        end
        chk({name, "_npulse"}, d, 32'(np), 32'(exp_np));
        chk({name, "_halted"}, d, 32'(w_halted[d]), 32'd1);
        if (exp_np == cfg_n(d)) chk({name, "_count"}, d, w_count[d], 32'((c0 + 1) % (1 << cfg_cw(d))));
    endtask

    initial begin
        int  c0;
        bit  ok;
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            halt_v[i] = 1'b0;
            step_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset values
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_pulse",  i, w_pulse[i], 32'd0);
            chk("rst_idx",    i, w_idx[i],   32'd0);
            chk("rst_count",  i, w_count[i], 32'd0);
            chk("rst_halted", i, 32'(w_halted[i]), 32'(cfg_sr(i) == 0));
        end

        // Free run: N=3 gives 001,010,100 three times, done on every third
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("t1_pulse", 0, w_pulse[0], 32'd1 << ((k - 1) % 3));
            chk("t1_done",  0, 32'(w_done[0]), 32'((k % 3) == 0));
        end
        chk("t1_count", 0, w_count[0], 32'd3);

        // Immediate halt during phase 1 (N=4): no phase 2, index 2 held
        wait_pulse(1, 1, "t3_wait");
        halt_v[1] = 1'b1;
        @(negedge clk);
        chk("t3_pulse",  1, w_pulse[1], 32'd0);
        chk("t3_halted", 1, 32'(w_halted[1]), 32'd1);
        chk("t3_idx",    1, w_idx[1], 32'd2);
        c0 = m[1].cnt;
        @(negedge clk);
        chk("t3_hold_idx", 1, w_idx[1], 32'd2);
        halt_v[1] = 1'b0;
        @(negedge clk);
        chk("t3_gap", 1, w_pulse[1], 32'd0);
        @(negedge clk);
        chk("t3_p2", 1, w_pulse[1], 32'd4);
        @(negedge clk);
        chk("t3_p3",    1, w_pulse[1], 32'd8);
        chk("t3_done",  1, 32'(w_done[1]), 32'd1);
        chk("t3_count", 1, w_count[1], 32'((c0 + 1) % 16));

        // Boundary halt during phase 1 (N=4): phases 2,3 still emitted
        wait_pulse(2, 1, "t2_wait");
        halt_v[2] = 1'b1;
        @(negedge clk);
        chk("t2_p2", 2, w_pulse[2], 32'd4);
        @(negedge clk);
        chk("t2_p3", 2, w_pulse[2], 32'd8);
        @(negedge clk);
        chk("t2_pulse",  2, w_pulse[2], 32'd0);
        chk("t2_halted", 2, 32'(w_halted[2]), 32'd1);
        chk("t2_idx",    2, w_idx[2], 32'd0);
        halt_v[2] = 1'b0;
        @(negedge clk);
        chk("t2_gap", 2, w_pulse[2], 32'd0);
        @(negedge clk);
        chk("t2_p0", 2, w_pulse[2], 32'd1);

        // Single-step: full cycle in boundary mode, one phase in immediate mode
        halt_v[0] = 1'b1;
        wait_halted(0, "t4_wait0");
        do_step(0, 3, "t4_m0");
        halt_v[3] = 1'b1;
        wait_halted(3, "t4_wait3");
        do_step(3, 1, "t4_m1");

        // Reset while stepping at phase 1, START_RUNNING=0 configuration
        halt_v[2] = 1'b1;
        wait_halted(2, "t6_wait");
        step_v[2] = 1'b1;
        @(negedge clk);
        step_v[2] = 1'b0;
        wait_pulse(2, 1, "t6_phase1");
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_pulse",  2, w_pulse[2], 32'd0);
        chk("t6_idx",    2, w_idx[2],   32'd0);
        chk("t6_count",  2, w_count[2], 32'd0);
        chk("t6_done",   2, 32'(w_done[2]), 32'd0);
        chk("t6_halted", 2, 32'(w_halted[2]), 32'd1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_idle", 2, w_pulse[2], 32'd0);
        end
        halt_v[2] = 1'b0;

        // Counter wrap with a 4-bit counter
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (w_count[1] == 32'd15) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("t5_reach15", 1);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (w_done[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("t5_done", 1);
        chk("t5_wrap", 1, w_count[1], 32'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NDUT; i++) begin
                if ($urandom_range(0, 99) < 12) halt_v[i] = ~halt_v[i];
                step_v[i] = ($urandom_range(0, 99) < 15);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_phase_sequencer
`default_nettype wire
